// File: rtl/led_pkg.sv
// Shared LED strip protocol constants and receiver state type.
// Timing constants are in clock cycles and are shared with the
// transmitter-side timing generator.
package led_pkg;

    localparam int unsigned W      = 24;    // bits per frame
    localparam int unsigned N_LEDS = 8;     // maximum frames per set

    localparam int unsigned T_MIN = 4;      // shorter high pulses are glitches
    localparam int unsigned T_BIT = 30;     // high width at or above this decodes as 1
    localparam int unsigned T_MAX = 100;    // longer high pulses are errors
    localparam int unsigned T_RST = 2500;   // low width at or above this is a latch gap

    localparam int unsigned HI_W  = $clog2(T_MAX + 2);
    localparam int unsigned LO_W  = $clog2(T_RST + 1);
    localparam int unsigned BIT_W = $clog2(W + 1);
    localparam int unsigned FRM_W = 4;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } rx_state_t;

endpackage

// File: rtl/din_sync.sv
// Two-flop synchroniser for the asynchronous LED data line.
// Ports: clk, rst (sync, active-high), din (async line), din_s (synchronised sample).
module din_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic din_s
);

    logic meta;

    // Metastability filter; din_s lags din by two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b0;
            din_s <= 1'b0;
        end else begin
            meta  <= din;
            din_s <= meta;
        end
    end

endmodule

// File: rtl/led_frame_receiver.sv
// Single-wire LED strip decoder: measures high pulses on the synchronised
// data line, deserialises bits MSB-first into W-bit frames and reports
// frames, completed sets (closed by a latch gap) and protocol errors.
// Ports: clk, rst (sync, active-high), din (async line);
//        frame_out/frame_idx with frame_valid pulse, set_count with
//        set_done pulse, err pulse.
module led_frame_receiver
    import led_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [W-1:0]     frame_out,
    output logic [IDX_W-1:0] frame_idx,
    output logic             frame_valid,
    output logic             set_done,
    output logic [FRM_W-1:0] set_count,
    output logic             err
);

    localparam logic [HI_W-1:0]  HI_SAT   = HI_W'(T_MAX + 1);
    localparam logic [LO_W-1:0]  LO_LAST  = LO_W'(T_RST - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

    logic din_s;

    din_sync u_din_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .din_s (din_s)
    );

    rx_state_t          state, state_d;
    logic [HI_W-1:0]    hi_cnt, hi_cnt_d, hi_inc;
    logic [LO_W-1:0]    lo_cnt, lo_cnt_d;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_d;
    logic [FRM_W-1:0]   frame_cnt, frame_cnt_d;
    logic [W-1:0]       shift_q, shift_d, shift_nx;
    logic [W-1:0]       frame_out_d;
    logic [IDX_W-1:0]   frame_idx_d;
    logic [FRM_W-1:0]   set_count_d;
    logic               frame_valid_d, set_done_d, fault;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SYNC;
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            bit_cnt     <= '0;
            frame_cnt   <= '0;
            shift_q     <= '0;
            frame_out   <= '0;
            frame_idx   <= '0;
            frame_valid <= 1'b0;
            set_done    <= 1'b0;
            set_count   <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_d;
            hi_cnt      <= hi_cnt_d;
            lo_cnt      <= lo_cnt_d;
            bit_cnt     <= bit_cnt_d;
            frame_cnt   <= frame_cnt_d;
            shift_q     <= shift_d;
            frame_out   <= frame_out_d;
            frame_idx   <= frame_idx_d;
            frame_valid <= frame_valid_d;
            set_done    <= set_done_d;
            set_count   <= set_count_d;
            err         <= fault;
        end
    end

    // Next-state, pulse-width decode and frame assembly.
    always_comb begin
        state_d       = state;
        hi_cnt_d      = hi_cnt;
        lo_cnt_d      = lo_cnt;
        bit_cnt_d     = bit_cnt;
        frame_cnt_d   = frame_cnt;
        shift_d       = shift_q;
        frame_out_d   = frame_out;
        frame_idx_d   = frame_idx;
        set_count_d   = set_count;
        frame_valid_d = 1'b0;
        set_done_d    = 1'b0;
        fault         = 1'b0;

        hi_inc   = (hi_cnt == HI_SAT) ? hi_cnt : hi_cnt + HI_W'(1);
        shift_nx = {shift_q[W-2:0], (hi_cnt >= HI_W'(T_BIT))};

        case (state)
            // Wait for a full latch gap so decoding never starts mid-stream.
            SYNC: begin
                if (din_s) begin
                    lo_cnt_d = '0;
                end else if (lo_cnt == LO_LAST) begin
                    lo_cnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    lo_cnt_d = lo_cnt + LO_W'(1);
                end
            end
            IDLE: begin
                if (din_s) begin
                    hi_cnt_d = HI_W'(1);
                    state_d  = HIGH;
                end
            end
            HIGH: begin
                if (din_s) begin
                    hi_cnt_d = hi_inc;
                    if (hi_inc > HI_W'(T_MAX)) begin
                        fault = 1'b1;
                    end
                end else if (hi_cnt < HI_W'(T_MIN)) begin
                    fault = 1'b1;
                end else begin
                    shift_d  = shift_nx;
                    lo_cnt_d = LO_W'(1);
                    state_d  = LOW;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (frame_cnt == FRM_W'(N_LEDS)) begin
                            fault = 1'b1;
                        end else begin
                            frame_out_d   = shift_nx;
                            frame_idx_d   = IDX_W'(frame_cnt);
                            frame_valid_d = 1'b1;
                            frame_cnt_d   = frame_cnt + FRM_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt + BIT_W'(1);
                    end
                end
            end
            LOW: begin
                if (din_s) begin
                    hi_cnt_d = HI_W'(1);
                    state_d  = HIGH;
                end else if (lo_cnt == LO_LAST) begin
                    // Latch gap: closes the set only on a frame boundary.
                    if (bit_cnt == '0) begin
                        set_done_d  = 1'b1;
                        set_count_d = frame_cnt;
                        frame_cnt_d = '0;
                        lo_cnt_d    = '0;
                        state_d     = IDLE;
                    end else begin
                        fault = 1'b1;
                    end
                end else begin
                    lo_cnt_d = lo_cnt + LO_W'(1);
                end
            end
            default: state_d = SYNC;
        endcase

        // Any protocol error drops partial data and resynchronises.
        if (fault) begin
            state_d     = SYNC;
            hi_cnt_d    = '0;
            lo_cnt_d    = '0;
            bit_cnt_d   = '0;
            frame_cnt_d = '0;
        end
    end

endmodule

// File: tb/tb_led_frame_receiver.sv
// Self-checking bench for led_frame_receiver. Stimulus is a list of
// (level, width) segments on din; the reference model decodes that list
// from the protocol rules and yields the expected event sequence.
module tb_led_frame_receiver;
    import led_pkg::*;

    localparam int TMIN = T_MIN;
    localparam int TBIT = T_BIT;
    localparam int TMAX = T_MAX;
    localparam int TRST = T_RST;
    localparam int NL   = N_LEDS;
    localparam int WB   = W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din = 1'b0;
    logic [W-1:0]  frame_out;
    logic [2:0]    frame_idx;
    logic          frame_valid;
    logic          set_done;
    logic [3:0]    set_count;
    logic          err;

    led_frame_receiver dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .frame_out   (frame_out),
        .frame_idx   (frame_idx),
        .frame_valid (frame_valid),
        .set_done    (set_done),
        .set_count   (set_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 frame (aux = idx), 1 set done (aux = count), 2 error
    typedef struct {
        int          kind;
        logic [23:0] data;
        int          aux;
        int          cyc;
    } ev_t;

    ev_t obs[$];
    ev_t exp_q[$];
    bit  seg_lvl[$];
    int  seg_len[$];
    int  seg_start[$];
    int  vecs = 0;
    int  miscompares = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) obs.push_back('{0, frame_out, int'(frame_idx), cyc});
            if (set_done)    obs.push_back('{1, 24'h0, int'(set_count), cyc});
            if (err)         obs.push_back('{2, 24'h0, 0, cyc});
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        seg_lvl.delete();
        seg_len.delete();
        seg_start.delete();
        obs.delete();
    endtask

    task automatic add_seg(input bit lvl, input int len);
        if (seg_lvl.size() > 0 && seg_lvl[seg_lvl.size()-1] == lvl)
            seg_len[seg_len.size()-1] = seg_len[seg_len.size()-1] + len;
        else begin
            seg_lvl.push_back(lvl);
            seg_len.push_back(len);
        end
    endtask

    task automatic add_bit(input int h, input int l);
        add_seg(1'b1, h);
        add_seg(1'b0, l);
    endtask

    // mode 0: nominal 40/20 high in 60 period; 1: fast; 2: random widths
    task automatic add_frame(input logic [23:0] d, input int mode);
        for (int i = WB - 1; i >= 0; i--) begin
            int h, l;
            case (mode)
                0: begin h = d[i] ? 40 : 20; l = 60 - h; end
                1: begin h = d[i] ? TBIT : TMIN + 1; l = 3; end
                default: begin
                    h = d[i] ? int'($urandom_range(60, TBIT)) : int'($urandom_range(TBIT - 1, TMIN));
                    l = int'($urandom_range(10, 1));
                end
            endcase
            add_bit(h, l);
        end
    endtask

    task automatic play();
        for (int s = 0; s < seg_len.size(); s++) begin
            seg_start.push_back(cyc);
            din = seg_lvl[s];
            repeat (seg_len[s]) begin @(posedge clk); #1; end
        end
        din = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
    endtask

    // Reference decoder working on whole pulse widths.
    task automatic build_expect();
        bit          synced = 1'b0;
        int          low_run = 0;
        int          nbits = 0;
        int          frames = 0;
        logic [23:0] bits = 24'h0;
        exp_q.delete();
        for (int s = 0; s < seg_len.size(); s++) begin
            int len = seg_len[s];
            if (!seg_lvl[s]) begin
                if (!synced) begin
                    low_run += len;
                    if (low_run >= TRST) synced = 1'b1;
                end else if (len >= TRST && (nbits != 0 || frames != 0)) begin
                    if (nbits == 0) begin
                        exp_q.push_back('{1, 24'h0, frames, 0});
                        frames = 0;
                    end else begin
                        exp_q.push_back('{2, 24'h0, 0, 0});
                        nbits = 0; frames = 0;
                        low_run = len - TRST;
                        synced = (low_run >= TRST);
                    end
                end
            end else if (!synced) begin
                low_run = 0;
            end else if (len > TMAX || len < TMIN) begin
                exp_q.push_back('{2, 24'h0, 0, 0});
                nbits = 0; frames = 0; synced = 1'b0;
                low_run = (len > TMAX) ? 0 : -1;
            end else begin
                bits = {bits[22:0], (len >= TBIT)};
                nbits++;
                if (nbits == WB) begin
                    nbits = 0;
                    if (frames == NL) begin
                        exp_q.push_back('{2, 24'h0, 0, 0});
                        frames = 0; synced = 1'b0; low_run = -1;
                    end else begin
                        exp_q.push_back('{0, bits, frames, 0});
                        frames++;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if (frame_out !== 24'h0) begin miscompares++; $display("FAIL reset_frame_out: got %h want 0", frame_out); end
        vecs++; if (frame_idx !== 3'd0) begin miscompares++; $display("FAIL reset_frame_idx: got %0d want 0", frame_idx); end
        vecs++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
        vecs++; if (set_done !== 1'b0) begin miscompares++; $display("FAIL reset_set_done: got %b want 0", set_done); end
        vecs++; if (set_count !== 4'd0) begin miscompares++; $display("FAIL reset_set_count: got %0d want 0", set_count); end
        vecs++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_basic();
        int f;
        do_reset();
        add_seg(1'b0, 2510);
        add_frame(24'hA5C3F0, 0);
        add_seg(1'b0, 2510);
        build_expect();
        play();
        vecs++;
        if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_count: got %0d events want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            vecs++;
            if (obs[i].kind !== exp_q[i].kind || obs[i].data !== exp_q[i].data || obs[i].aux !== exp_q[i].aux) begin
                miscompares++;
                $display("FAIL basic_ev%0d: got kind %0d data %h aux %0d want kind %0d data %h aux %0d", i, obs[i].kind, obs[i].data, obs[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
            end
        end
        f = seg_start[seg_start.size()-1];
        if (obs.size() >= 2) begin
            vecs++; if (obs[0].data !== 24'hA5C3F0) begin miscompares++; $display("FAIL basic_data: got %h want a5c3f0", obs[0].data); end
            vecs++; if (obs[0].cyc !== f + 3) begin miscompares++; $display("FAIL basic_frame_latency: got cycle %0d want %0d", obs[0].cyc, f + 3); end
            vecs++; if (obs[1].cyc !== f + 2502) begin miscompares++; $display("FAIL basic_set_latency: got cycle %0d want %0d", obs[1].cyc, f + 2502); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        add_seg(1'b0, 2510);
        for (int k = 1; k <= 8; k++) add_frame(24'(k), 1);
        add_seg(1'b0, 2510);
        build_expect();
        play();
        vecs++;
        if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL b2b_count: got %0d events want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            vecs++;
            if (obs[i].kind !== exp_q[i].kind || obs[i].data !== exp_q[i].data || obs[i].aux !== exp_q[i].aux) begin
                miscompares++;
                $display("FAIL b2b_ev%0d: got kind %0d data %h aux %0d want kind %0d data %h aux %0d", i, obs[i].kind, obs[i].data, obs[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
            end
        end
    endtask

    task automatic test_midstream();
        do_reset();
        for (int k = 0; k < 9; k++) add_bit(k[0] ? 40 : 20, k[0] ? 20 : 40);
        add_seg(1'b0, 2510);
        add_frame(24'h5A0FF1, 1);
        add_seg(1'b0, 2510);
        build_expect();
        play();
        vecs++;
        if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL mid_count: got %0d events want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            vecs++;
            if (obs[i].kind !== exp_q[i].kind || obs[i].data !== exp_q[i].data || obs[i].aux !== exp_q[i].aux) begin
                miscompares++;
                $display("FAIL mid_ev%0d: got kind %0d data %h aux %0d want kind %0d data %h aux %0d", i, obs[i].kind, obs[i].data, obs[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
            end
        end
    endtask

    task automatic test_errors();
        do_reset();
        add_seg(1'b0, 2510);
        add_frame(24'h111111, 1);
        add_bit(30, 3); add_bit(5, 3); add_bit(2, 2700);          // glitch
        add_frame(24'h222222, 1);
        add_bit(30, 3); add_bit(120, 2700);                       // over-long high
        for (int k = 0; k < 10; k++) add_bit(30, 3);
        add_seg(1'b0, 5300);                                      // latch mid-frame
        for (int k = 0; k < 9; k++) add_frame(24'h0F0000 | 24'(k), 1);  // ninth overflows
        add_seg(1'b0, 2700);
        add_frame(24'hABCDEF, 1);
        add_seg(1'b0, 2510);
        build_expect();
        play();
        vecs++;
        if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL err_count: got %0d events want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            vecs++;
            if (obs[i].kind !== exp_q[i].kind || obs[i].data !== exp_q[i].data || obs[i].aux !== exp_q[i].aux) begin
                miscompares++;
                $display("FAIL err_ev%0d: got kind %0d data %h aux %0d want kind %0d data %h aux %0d", i, obs[i].kind, obs[i].data, obs[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
            end
        end
    endtask

    task automatic test_boundary();
        logic [19:0] tail = 20'hA5A5A;
        do_reset();
        add_seg(1'b0, 2510);
        add_bit(29, 31);
        add_bit(30, 30);
        add_bit(100, 2499);
        add_bit(TMIN, 56);
        for (int i = 19; i >= 0; i--) add_bit(tail[i] ? 40 : 20, tail[i] ? 20 : 40);
        add_seg(1'b0, 2510);
        build_expect();
        play();
        vecs++;
        if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL bound_count: got %0d events want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            vecs++;
            if (obs[i].kind !== exp_q[i].kind || obs[i].data !== exp_q[i].data || obs[i].aux !== exp_q[i].aux) begin
                miscompares++;
                $display("FAIL bound_ev%0d: got kind %0d data %h aux %0d want kind %0d data %h aux %0d", i, obs[i].kind, obs[i].data, obs[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
            end
        end
        if (obs.size() > 0) begin
            vecs++; if (obs[0].data !== 24'h6A5A5A) begin miscompares++; $display("FAIL bound_data: got %h want 6a5a5a", obs[0].data); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_seg(1'b0, 2510);
        add_frame(24'hC3C3C3, 1);
        add_seg(1'b0, 2510);
        for (int k = 0; k < 12; k++) add_bit(30, 3);
        build_expect();
        play();
        vecs++;
        if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL rstmid_count: got %0d events want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            vecs++;
            if (obs[i].kind !== exp_q[i].kind || obs[i].data !== exp_q[i].data || obs[i].aux !== exp_q[i].aux) begin
                miscompares++;
                $display("FAIL rstmid_ev%0d: got kind %0d data %h aux %0d want kind %0d data %h aux %0d", i, obs[i].kind, obs[i].data, obs[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        vecs++; if (frame_out !== 24'h0) begin miscompares++; $display("FAIL rstmid_frame_out: got %h want 0", frame_out); end
        vecs++; if (set_count !== 4'd0) begin miscompares++; $display("FAIL rstmid_set_count: got %0d want 0", set_count); end
        vecs++; if ({frame_valid, set_done, err, frame_idx} !== 6'd0) begin miscompares++; $display("FAIL rstmid_pulses: got %b want 0", {frame_valid, set_done, err, frame_idx}); end
        do_reset();
        add_seg(1'b0, 2510);
        add_frame(24'h0F1E2D, 1);
        add_seg(1'b0, 2510);
        build_expect();
        play();
        vecs++;
        if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL rstmid2_count: got %0d events want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            vecs++;
            if (obs[i].kind !== exp_q[i].kind || obs[i].data !== exp_q[i].data || obs[i].aux !== exp_q[i].aux) begin
                miscompares++;
                $display("FAIL rstmid2_ev%0d: got kind %0d data %h aux %0d want kind %0d data %h aux %0d", i, obs[i].kind, obs[i].data, obs[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 2; it++) begin
            int n;
            do_reset();
            add_seg(1'b0, 2510);
            n = int'($urandom_range(6, 1));
            for (int k = 0; k < n; k++) add_frame(24'($urandom), 2);
            add_seg(1'b0, 2510);
            build_expect();
            play();
            vecs++;
            if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL rand%0d_count: got %0d events want %0d", it, obs.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs.size()) begin
                vecs++;
                if (obs[i].kind !== exp_q[i].kind || obs[i].data !== exp_q[i].data || obs[i].aux !== exp_q[i].aux) begin
                    miscompares++;
                    $display("FAIL rand%0d_ev%0d: got kind %0d data %h aux %0d want kind %0d data %h aux %0d", it, i, obs[i].kind, obs[i].data, obs[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_midstream();
        test_errors();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
